trace_checker: RTL and testbench
================================

TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameter: DEPTH, default 8, number of golden-trace FIFO entries (power of two, >= 2).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 debug_wb_pc  input  32  PC of the instruction retiring in WB.
REQ-006 debug_wb_rf_wen  input  4  byte write enables of the retiring register write.
REQ-007 debug_wb_rf_wnum  input  5  destination register number.
REQ-008 debug_wb_rf_wdata  input  32  register write data.
REQ-009 gold_valid  input  1  golden entry offered.
REQ-010 gold_ready  output  1  checker accepts the golden entry this cycle.
REQ-011 gold_pc / gold_wnum / gold_wdata  input  32/5/32  expected PC, register number and data.
REQ-012 gold_end  input  1  marks the final golden entry of the trace.
REQ-013 cmp_count  output  32  number of matched retire events.
REQ-014 err  output  1  sticky mismatch or underflow flag.
REQ-015 underflow  output  1  sticky flag: retire event with golden FIFO empty.
REQ-016 pass  output  1  sticky flag: entry marked gold_end matched with no error.
REQ-017 err_pc / err_wnum / err_exp_wdata / err_act_wdata  output  32/5/32/32  capture of the first failing event.

Function
REQ-018 State machine RUN, ERROR, DONE; ERROR and DONE are terminal until reset.
REQ-019 gold_ready = (state == RUN) and FIFO not full and reset low; a push occurs on gold_valid and gold_ready.
REQ-020 Retire event ev = (state == RUN) and (debug_wb_rf_wen != 0) and (debug_wb_rf_wnum != 0); all other cycles are ignored.
REQ-021 On ev with FIFO non-empty: pop the head, compare pc, wnum and wdata against the debug inputs in the same cycle.
REQ-022 Match: cmp_count increments (saturating at 0xFFFFFFFF); if the head has gold_end set -> DONE, pass = 1.
REQ-023 Mismatch: -> ERROR, err = 1, err_* capture the head's pc, wnum and wdata plus debug_wb_rf_wdata.
REQ-024 ev with FIFO empty: -> ERROR, err = 1, underflow = 1, err_pc/err_wnum/err_act_wdata capture the debug inputs, err_exp_wdata = 0.
REQ-025 No bypass: an entry pushed in the same cycle as ev is not visible to that ev; ev on an empty FIFO is underflow even with a simultaneous push.
REQ-026 Push and pop in the same cycle on a non-empty, non-full FIFO: occupancy is unchanged; pointers wrap modulo DEPTH.
REQ-027 Flags and captures update on the clock edge of the event and are visible the following cycle; captures hold the first failure only.
REQ-028 In ERROR and DONE: no pushes, no pops, cmp_count frozen.

Reset
REQ-029 Reset asserted: state RUN, FIFO empty, gold_ready 0, cmp_count 0, err/underflow/pass 0, all err_* 0.
REQ-030 Reset asserted mid-trace discards all FIFO contents and flags immediately; gold_ready goes to 1 on the first cycle after deassertion.

Configuration
REQ-031 Macro TRACE_CMP_BYTE_MASK_EN defined: wdata is compared only on bytes whose debug_wb_rf_wen bit is 1; other bytes are don't-care.
REQ-032 Macro TRACE_CMP_BYTE_MASK_EN undefined: the full 32-bit wdata is compared whenever ev fires; pc and wnum are always fully compared.

Verification
REQ-033 Push 3 entries (last with gold_end); retire 3 matching events -> cmp_count = 3, pass = 1, err = 0, state DONE, gold_ready = 0.
REQ-034 Push pc=0x1c000000, wnum=4, wdata=0x12345678; retire with wdata 0x12345679 -> err = 1, err_exp_wdata = 0x12345678, err_act_wdata = 0x12345679, cmp_count = 0.
REQ-035 Retire event wnum=5 on an empty FIFO while gold_valid is high -> underflow = 1, err = 1, err_exp_wdata = 0; the pushed entry is not consumed.
REQ-036 Push DEPTH entries with no retires -> gold_ready = 0; one retire plus gold_valid in the same cycle -> the next cycle's push is accepted and occupancy is DEPTH again; entries pop in order across the wrap.
REQ-037 rf_wen=4'b0001, expected 0x000000AA, actual 0xFFFFFFAA -> match with TRACE_CMP_BYTE_MASK_EN defined; err = 1 without it.
REQ-038 Events with wnum=0 or wen=0 -> no pop, no count change; reset asserted after 2 matches -> all outputs 0 within the same cycle.

Source files
------------

// File: rtl/trace_checker.sv
// trace_checker: checks WB retire events against a golden trace held in a FIFO.
// Build option TRACE_CMP_BYTE_MASK_EN: compare wdata only on bytes enabled by debug_wb_rf_wen.
module trace_checker #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] debug_wb_pc,
    input  logic [3:0]  debug_wb_rf_wen,
    input  logic [4:0]  debug_wb_rf_wnum,
    input  logic [31:0] debug_wb_rf_wdata,
    input  logic        gold_valid,
    output logic        gold_ready,
    input  logic [31:0] gold_pc,
    input  logic [4:0]  gold_wnum,
    input  logic [31:0] gold_wdata,
    input  logic        gold_end,
    output logic [31:0] cmp_count,
    output logic        err,
    output logic        underflow,
    output logic        pass,
    output logic [31:0] err_pc,
    output logic [4:0]  err_wnum,
    output logic [31:0] err_exp_wdata,
    output logic [31:0] err_act_wdata
);
    // state | meaning
    // RUN   | accepting golden entries and comparing retire events
    // ERROR | mismatch or underflow seen; frozen until reset
    // DONE  | final golden entry matched cleanly; frozen until reset
    typedef enum logic [1:0] {RUN = 2'd0, ERROR = 2'd1, DONE = 2'd2} state_t;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t state, state_nxt;

    logic [31:0] mem_pc    [DEPTH];
    logic [4:0]  mem_wnum  [DEPTH];
    logic [31:0] mem_wdata [DEPTH];
    logic        mem_end   [DEPTH];

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          full, empty, ev, push, pop, hit, wdata_eq;
    logic [31:0]   wdata_mask, head_pc, head_wdata;
    logic [4:0]    head_wnum;
    logic          head_end;

    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign head_pc    = mem_pc[rd_ptr];
    assign head_wnum  = mem_wnum[rd_ptr];
    assign head_wdata = mem_wdata[rd_ptr];
    assign head_end   = mem_end[rd_ptr];

`ifdef TRACE_CMP_BYTE_MASK_EN
    assign wdata_mask = {{8{debug_wb_rf_wen[3]}}, {8{debug_wb_rf_wen[2]}},
                         {8{debug_wb_rf_wen[1]}}, {8{debug_wb_rf_wen[0]}}};
`else
    assign wdata_mask = '1;
`endif

    assign wdata_eq = (((head_wdata ^ debug_wb_rf_wdata) & wdata_mask) == 32'd0);
    assign hit      = (head_pc == debug_wb_pc) && (head_wnum == debug_wb_rf_wnum) && wdata_eq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (ev) begin
            if (empty || !hit) state_nxt = ERROR;
            else if (head_end) state_nxt = DONE;
        end
    end

    // Head is compared before any same-cycle push lands, so a push never satisfies this ev.
    always_comb begin
        gold_ready = (state == RUN) && !full && !reset;
        ev         = (state == RUN) && (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
        push       = gold_valid && gold_ready;
        pop        = ev && !empty;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]    <= gold_pc;
            mem_wnum[wr_ptr]  <= gold_wnum;
            mem_wdata[wr_ptr] <= gold_wdata;
            mem_end[wr_ptr]   <= gold_end;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ev only fires in RUN, so the first failure is the only one ever captured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_count     <= '0;
            err           <= 1'b0;
            underflow     <= 1'b0;
            pass          <= 1'b0;
            err_pc        <= '0;
            err_wnum      <= '0;
            err_exp_wdata <= '0;
            err_act_wdata <= '0;
        end else if (ev) begin
            if (empty) begin
                err           <= 1'b1;
                underflow     <= 1'b1;
                err_pc        <= debug_wb_pc;
                err_wnum      <= debug_wb_rf_wnum;
                err_exp_wdata <= '0;
                err_act_wdata <= debug_wb_rf_wdata;
            end else if (!hit) begin
                err           <= 1'b1;
                err_pc        <= head_pc;
                err_wnum      <= head_wnum;
                err_exp_wdata <= head_wdata;
                err_act_wdata <= debug_wb_rf_wdata;
            end else begin
                if (cmp_count != 32'hFFFF_FFFF) cmp_count <= cmp_count + 32'd1;
                if (head_end) pass <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trace_checker.sv
// Bench for trace_checker: directed scenarios plus randomized traffic against a queue-based model.
module tb_trace_checker;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;
    logic        gold_valid;
    logic        gold_ready;
    logic [31:0] gold_pc;
    logic [4:0]  gold_wnum;
    logic [31:0] gold_wdata;
    logic        gold_end;
    logic [31:0] cmp_count;
    logic        err, underflow, pass;
    logic [31:0] err_pc, err_exp_wdata, err_act_wdata;
    logic [4:0]  err_wnum;

    trace_checker #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
        .gold_valid(gold_valid), .gold_ready(gold_ready),
        .gold_pc(gold_pc), .gold_wnum(gold_wnum), .gold_wdata(gold_wdata), .gold_end(gold_end),
        .cmp_count(cmp_count), .err(err), .underflow(underflow), .pass(pass),
        .err_pc(err_pc), .err_wnum(err_wnum),
        .err_exp_wdata(err_exp_wdata), .err_act_wdata(err_act_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wdata;
        logic        e;
    } ent_t;

    // Reference model: golden queue plus sticky outcome flags.
    ent_t        mq[$];
    logic        m_err = 1'b0, m_pass = 1'b0, m_uf = 1'b0;
    logic [31:0] m_cnt = '0, m_epc = '0, m_eexp = '0, m_eact = '0;
    logic [4:0]  m_ewnum = '0;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] wen);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = wen[b] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic bit wdata_ok(input logic [31:0] e, input logic [31:0] a, input logic [3:0] wen);
`ifdef TRACE_CMP_BYTE_MASK_EN
        for (int b = 0; b < 4; b++)
            if (wen[b] && (e[8*b +: 8] != a[8*b +: 8])) return 1'b0;
        return 1'b1;
`else
        return e == a;
`endif
    endfunction

    task automatic model_clear();
        mq.delete();
        m_err = 0; m_pass = 0; m_uf = 0; m_cnt = 0;
        m_epc = 0; m_ewnum = 0; m_eexp = 0; m_eact = 0;
    endtask

    task automatic model_step();
        bit   running, room, retire_ev;
        ent_t h;
        running   = !m_err && !m_pass;
        room      = running && (mq.size() < DEPTH);
        retire_ev = running && (debug_wb_rf_wen != 0) && (debug_wb_rf_wnum != 0);
        if (retire_ev) begin
            if (mq.size() == 0) begin
                m_err = 1; m_uf = 1;
                m_epc = debug_wb_pc; m_ewnum = debug_wb_rf_wnum;
                m_eexp = 0; m_eact = debug_wb_rf_wdata;
            end else begin
                h = mq.pop_front();
                if (h.pc == debug_wb_pc && h.wnum == debug_wb_rf_wnum &&
                    wdata_ok(h.wdata, debug_wb_rf_wdata, debug_wb_rf_wen)) begin
                    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                    if (h.e) m_pass = 1;
                end else begin
                    m_err = 1;
                    m_epc = h.pc; m_ewnum = h.wnum;
                    m_eexp = h.wdata; m_eact = debug_wb_rf_wdata;
                end
            end
        end
        if (gold_valid && room) begin
            h.pc = gold_pc; h.wnum = gold_wnum; h.wdata = gold_wdata; h.e = gold_end;
            mq.push_back(h);
        end
    endtask

    // Inputs change at negedge+1; the model advances on the same rising edge as the DUT.
    task automatic cyc();
        @(posedge clk);
        if (reset) model_clear();
        else       model_step();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("gold_ready", {31'd0, gold_ready},
                {31'd0, !m_err && !m_pass && (mq.size() < DEPTH) && !reset});
            chk("cmp_count", cmp_count, m_cnt);
            chk("err", {31'd0, err}, {31'd0, m_err});
            chk("underflow", {31'd0, underflow}, {31'd0, m_uf});
            chk("pass", {31'd0, pass}, {31'd0, m_pass});
            chk("err_pc", err_pc, m_epc);
            chk("err_wnum", {27'd0, err_wnum}, {27'd0, m_ewnum});
            chk("err_exp_wdata", err_exp_wdata, m_eexp);
            chk("err_act_wdata", err_act_wdata, m_eact);
        end
    end

    task automatic idle();
        gold_valid = 0; gold_pc = 0; gold_wnum = 0; gold_wdata = 0; gold_end = 0;
        debug_wb_pc = 0; debug_wb_rf_wen = 0; debug_wb_rf_wnum = 0; debug_wb_rf_wdata = 0;
    endtask

    task automatic offer(input ent_t x);
        gold_valid = 1; gold_pc = x.pc; gold_wnum = x.wnum; gold_wdata = x.wdata; gold_end = x.e;
    endtask

    task automatic no_offer();
        gold_valid = 0; gold_pc = 0; gold_wnum = 0; gold_wdata = 0; gold_end = 0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [4:0] wnum,
                          input logic [31:0] wdata, input logic [3:0] wen);
        debug_wb_pc = pc; debug_wb_rf_wnum = wnum; debug_wb_rf_wdata = wdata; debug_wb_rf_wen = wen;
    endtask

    task automatic no_retire();
        debug_wb_pc = 0; debug_wb_rf_wnum = 0; debug_wb_rf_wdata = 0; debug_wb_rf_wen = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        cyc();
        reset = 0;
        cyc();
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic [4:0] wnum,
                                input logic [31:0] wdata, input logic e);
        ent_t x;
        x.pc = pc; x.wnum = wnum; x.wdata = wdata; x.e = e;
        return x;
    endfunction

    ent_t d[DEPTH+1];
    ent_t h;
    int   r;

    initial begin
        idle();
        reset = 1;
        cyc();
        cyc();
        chk("lit_rst_ready", {31'd0, gold_ready}, 32'd0);
        chk("lit_rst_count", cmp_count, 32'd0);
        chk("lit_rst_err", {31'd0, err}, 32'd0);
        chk("lit_rst_errpc", err_pc, 32'd0);
        cmp_en = 1;
        reset = 0;
        cyc();
        chk("lit_ready_after_rst", {31'd0, gold_ready}, 32'd1);

        // three-entry trace ending cleanly
        for (int i = 0; i < 3; i++) begin
            d[i] = mk(32'h1c00_0000 + 32'(4*i), 5'(i + 1), 32'hA0 + 32'(i), i == 2);
            offer(d[i]);
            cyc();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            retire(d[i].pc, d[i].wnum, d[i].wdata, 4'hF);
            cyc();
        end
        idle();
        cyc();
        chk("lit_done_count", cmp_count, 32'd3);
        chk("lit_done_pass", {31'd0, pass}, 32'd1);
        chk("lit_done_err", {31'd0, err}, 32'd0);
        chk("lit_done_ready", {31'd0, gold_ready}, 32'd0);

        // wdata mismatch
        do_reset();
        offer(mk(32'h1c00_0000, 5'd4, 32'h1234_5678, 1'b0));
        cyc();
        idle();
        retire(32'h1c00_0000, 5'd4, 32'h1234_5679, 4'hF);
        cyc();
        idle();
        chk("lit_mm_err", {31'd0, err}, 32'd1);
        chk("lit_mm_exp", err_exp_wdata, 32'h1234_5678);
        chk("lit_mm_act", err_act_wdata, 32'h1234_5679);
        chk("lit_mm_count", cmp_count, 32'd0);
        chk("lit_mm_pc", err_pc, 32'h1c00_0000);

        // underflow with simultaneous push
        do_reset();
        offer(mk(32'h1c00_0100, 5'd5, 32'h5555_0000, 1'b0));
        retire(32'h1c00_0200, 5'd5, 32'hDEAD_BEEF, 4'hF);
        cyc();
        idle();
        chk("lit_uf_flag", {31'd0, underflow}, 32'd1);
        chk("lit_uf_err", {31'd0, err}, 32'd1);
        chk("lit_uf_exp", err_exp_wdata, 32'd0);
        chk("lit_uf_pc", err_pc, 32'h1c00_0200);
        chk("lit_uf_count", cmp_count, 32'd0);

        // fill, pop+offer while full, refill, drain across pointer wrap
        do_reset();
        for (int i = 0; i <= DEPTH; i++)
            d[i] = mk(32'h1c00_1000 + 32'(4*i), 5'((i % 31) + 1), 32'hC0DE_0000 + 32'(i), i == DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            offer(d[i]);
            cyc();
        end
        idle();
        chk("lit_full_ready", {31'd0, gold_ready}, 32'd0);
        offer(d[DEPTH]);
        retire(d[0].pc, d[0].wnum, d[0].wdata, 4'hF);
        cyc();
        chk("lit_after_pop_ready", {31'd0, gold_ready}, 32'd1);
        no_retire();
        cyc();
        idle();
        chk("lit_refull_ready", {31'd0, gold_ready}, 32'd0);
        for (int i = 1; i <= DEPTH; i++) begin
            retire(d[i].pc, d[i].wnum, d[i].wdata, 4'hF);
            cyc();
        end
        idle();
        chk("lit_wrap_count", cmp_count, 32'(DEPTH + 1));
        chk("lit_wrap_pass", {31'd0, pass}, 32'd1);
        chk("lit_wrap_err", {31'd0, err}, 32'd0);

        // single enabled byte, upper bytes differ
        do_reset();
        offer(mk(32'h1c00_2000, 5'd3, 32'h0000_00AA, 1'b0));
        cyc();
        idle();
        retire(32'h1c00_2000, 5'd3, 32'hFFFF_FFAA, 4'b0001);
        cyc();
        idle();
`ifdef TRACE_CMP_BYTE_MASK_EN
        chk("lit_mask_err", {31'd0, err}, 32'd0);
        chk("lit_mask_count", cmp_count, 32'd1);
`else
        chk("lit_mask_err", {31'd0, err}, 32'd1);
        chk("lit_mask_act", err_act_wdata, 32'hFFFF_FFAA);
`endif

        // non-events, two matches, then reset mid-trace
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d[i] = mk(32'h1c00_3000 + 32'(4*i), 5'(i + 7), 32'h7700_0000 + 32'(i), 1'b0);
            offer(d[i]);
            cyc();
        end
        idle();
        retire(d[0].pc, 5'd0, d[0].wdata, 4'hF);
        cyc();
        retire(d[0].pc, d[0].wnum, d[0].wdata, 4'h0);
        cyc();
        chk("lit_nonev_count", cmp_count, 32'd0);
        chk("lit_nonev_err", {31'd0, err}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            retire(d[i].pc, d[i].wnum, d[i].wdata, 4'hF);
            cyc();
        end
        idle();
        chk("lit_two_count", cmp_count, 32'd2);
        reset = 1;
        #1;
        chk("lit_async_count", cmp_count, 32'd0);
        chk("lit_async_ready", {31'd0, gold_ready}, 32'd0);
        chk("lit_async_err", {31'd0, err}, 32'd0);
        cyc();
        reset = 0;
        cyc();

        // randomized traffic
        for (int t = 0; t < 30; t++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                idle();
                if ($urandom_range(0, 1) == 1)
                    offer(mk({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, 5'($urandom_range(1, 31)),
                             $urandom, $urandom_range(0, 39) == 0));
                r = $urandom_range(0, 19);
                debug_wb_rf_wen = 4'($urandom_range(1, 15));
                if (r < 8) begin
                    retire($urandom, 5'($urandom_range(0, 31)), $urandom, 4'h0);
                end else if (r < 10) begin
                    debug_wb_pc = $urandom; debug_wb_rf_wnum = 5'd0; debug_wb_rf_wdata = $urandom;
                end else if (mq.size() > 0) begin
                    h = mq[0];
                    debug_wb_pc = h.pc; debug_wb_rf_wnum = h.wnum;
`ifdef TRACE_CMP_BYTE_MASK_EN
                    debug_wb_rf_wdata = h.wdata ^ ($urandom & ~byte_mask(debug_wb_rf_wen));
`else
                    debug_wb_rf_wdata = h.wdata;
`endif
                    if (r == 19) begin
                        case ($urandom_range(0, 2))
                            0: debug_wb_pc = h.pc ^ (32'd1 << $urandom_range(0, 31));
                            1: debug_wb_rf_wnum = h.wnum ^ 5'd1;
                            default: debug_wb_rf_wdata = h.wdata ^ 32'h0100_0000;
                        endcase
                    end
                end else if ($urandom_range(0, 9) != 0) begin
                    no_retire();
                end else begin
                    retire($urandom, 5'($urandom_range(1, 31)), $urandom, debug_wb_rf_wen);
                end
                cyc();
            end
        end

        idle();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
